result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/display_pkg.sv | 44 ++++
 rtl/seg7_decoder.sv | 16 +
 rtl/result_display.sv | 158 +++++++++++++++
 tb/tb_result_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the result_display block: FSM states,
// active-low seven-segment patterns {g,f,e,d,c,b,a} and digit-index values.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_SIGN     = 2'd3;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = bcd[4*i +: 4];
        end
        return (adj << 1) | {11'd0, bit_in};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank && i_digit <= 4'd9)
            o_seg = SEG_DIGITS[i_digit];
    end

endmodule

// File: rtl/result_display.sv
// Sequential double-dabble converter driving a 4-digit multiplexed display.
// Optional feature: define SIGNED_DISPLAY_EN for two's-complement input with a minus sign on digit 3.
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  result_in,
    input  logic        update,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_bin;
    logic [11:0]        r_bcd;
    logic [2:0]         r_bit_cnt;
    logic [11:0]        r_bcd_out;
    logic [11:0]        r_disp;
    logic [CNT_W-1:0]   r_scan_cnt;
    logic [1:0]         r_digit;
    logic [7:0]         w_mag;
    logic [3:0]         w_dig_val;
    logic               w_dig_blank;
    logic               w_minus;
    logic [6:0]         w_dec_seg;

`ifdef SIGNED_DISPLAY_EN
    logic w_neg;
    logic r_neg;
    logic r_disp_neg;

    assign w_neg = result_in[7];
    // 8-bit negate of 8'h80 wraps to 8'h80, which read unsigned is the required magnitude 128.
    assign w_mag = w_neg ? (8'd0 - result_in) : result_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg      <= 1'b0;
            r_disp_neg <= 1'b0;
        end else begin
            if (r_state == IDLE && update)
                r_neg <= w_neg;
            if (r_state == DONE)
                r_disp_neg <= r_neg;
        end
    end
`else
    assign w_mag = result_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (update) w_next = SHIFT;
            SHIFT:   if (r_bit_cnt == 3'd7) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // NOTE: every register here, including the working datapath, is cleared so an aborted conversion leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_bcd_out <= '0;
            r_disp    <= '0;
        end else begin
            case (r_state)
                IDLE: if (update) begin
                    r_bin     <= w_mag;
                    r_bcd     <= '0;
                    r_bit_cnt <= '0;
                end
                SHIFT: begin
                    r_bcd     <= dabble_step(r_bcd, r_bin[7]);
                    r_bin     <= {r_bin[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                DONE: begin
                    r_bcd_out <= r_bcd;
                    r_disp    <= r_bcd;
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = r_bcd_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= DIG_UNITS;
        end else if (r_scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_dig_val   = 4'd0;
        w_dig_blank = 1'b1;
        w_minus     = 1'b0;
        case (r_digit)
            DIG_UNITS: begin
                w_dig_val   = r_disp[3:0];
                w_dig_blank = 1'b0;
            end
            DIG_TENS: begin
                w_dig_val   = r_disp[7:4];
                w_dig_blank = (r_disp[11:8] == 4'd0) && (r_disp[7:4] == 4'd0);
            end
            DIG_HUNDREDS: begin
                w_dig_val   = r_disp[11:8];
                w_dig_blank = (r_disp[11:8] == 4'd0);
            end
            DIG_SIGN: begin
`ifdef SIGNED_DISPLAY_EN
                w_minus = r_disp_neg;
`endif
            end
            default: ;
        endcase
    end

    seg7_decoder u_dec (
        .i_digit (w_dig_val),
        .i_blank (w_dig_blank),
        .o_seg   (w_dec_seg)
    );

    assign seg = w_minus ? SEG_MINUS : w_dec_seg;
    assign an  = ~(4'b0001 << r_digit);

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed corner cases plus random values
// compared against an arithmetic decimal model. Honours SIGNED_DISPLAY_EN.
module tb_result_display;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  result_in;
    logic        update;
    logic        busy;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    int   model_mag = 0;
    bit   model_neg = 0;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .result_in (result_in),
        .update    (update),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        int h, t, u;
        h = model_mag / 100;
        t = (model_mag / 10) % 10;
        u = model_mag % 10;
        case (d)
            0:       return seg_tab[u];
            1:       return (h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
            2:       return (h == 0) ? 7'b1111111 : seg_tab[h];
            default: return model_neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion, optionally poke a second update while busy, then check timing and result.
    task automatic convert(input logic [7:0] val, input int poke_at, input logic [7:0] poke_val);
        int   busy_cnt;
        int   mag;
        bit   neg;
        logic [11:0] prev;
`ifdef SIGNED_DISPLAY_EN
        neg = val[7];
        mag = neg ? 256 - int'(val) : int'(val);
`else
        neg = 1'b0;
        mag = int'(val);
`endif
        prev = exp_bcd(model_mag);
        result_in = val;
        update    = 1'b1;
        tick();
        update    = 1'b0;
        result_in = ~val;
        check("busy_start", busy, 1);
        check("bcd_hold", bcd_out, prev);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 30) begin
            busy_cnt++;
            if (busy_cnt == poke_at) begin
                result_in = poke_val;
                update    = 1'b1;
            end
            tick();
            update = 1'b0;
        end
        check($sformatf("busy_len_%0d", val), busy_cnt, 9);
        check($sformatf("bcd_%0d", val), bcd_out, exp_bcd(mag));
        model_mag = mag;
        model_neg = neg;
    endtask

    task automatic check_display();
        for (int d = 0; d < 4; d++) begin
            logic [3:0] want_an;
            int waited;
            want_an    = 4'b1111;
            want_an[d] = 1'b0;
            waited     = 0;
            while (an !== want_an && waited < 40) begin
                tick();
                waited++;
            end
            check($sformatf("an_d%0d", d), an, want_an);
            check($sformatf("seg_d%0d_v%0d", d, model_mag), seg, exp_seg(d));
        end
    endtask

    initial begin
        int busy_seen;
        reset     = 1'b1;
        update    = 1'b0;
        result_in = 8'd0;
        repeat (3) tick();

        check("rst_busy", busy, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);

        // Scan order and dwell straight out of reset.
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] want;
            if (i > 0) tick();
            want = 4'b1111;
            want[(i / DIV) % 4] = 1'b0;
            check($sformatf("scan_%0d", i), an, want);
        end

        convert(8'd0, -1, 8'd0);
        check_display();

        convert(8'd255, -1, 8'd0);
        check_display();

        convert(8'd7, 3, 8'd99);
        busy_seen = 0;
        repeat (12) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        check("no_queue_busy", busy_seen, 0);
        check("no_queue_bcd", bcd_out, 12'h007);
        check_display();

`ifdef SIGNED_DISPLAY_EN
        convert(8'hF6, -1, 8'd0);
        check("signed_f6", bcd_out, 12'h010);
        check_display();
        convert(8'h80, -1, 8'd0);
        check("signed_80", bcd_out, 12'h128);
        check_display();
`endif

        for (int n = 0; n < 24; n++) begin
            convert(8'($urandom_range(0, 255)), -1, 8'd0);
            if (n % 4 == 0) check_display();
        end

        // Abort during the fourth SHIFT cycle of a conversion of 200.
        result_in = 8'd200;
        update    = 1'b1;
        tick();
        update = 1'b0;
        repeat (3) tick();
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd_out, 0);
        check("abort_an", an, 4'b1110);
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        reset = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        check("post_abort_busy", busy_seen, 0);
        check("post_abort_bcd", bcd_out, 0);
        model_mag = 0;
        model_neg = 1'b0;
        check_display();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
